alu_exec_ctl: RTL

Execute-stage controller that sits directly upstream of the combinational `alu32_2x2` and downstream of register-file read. It accepts one operation at a time over a valid/ready handshake and holds the ALU operands stable for a fixed settle budget. It then captures `ql`/`qh`/`fout` and sequences the result to the register-file write port. Dual-result ops (0 = pair move, 4 = 32x32 multiply) take two write beats.

---
 rtl/alu_exec_ctl_if.sv | 49 ++++
 rtl/alu_exec_ctl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_exec_ctl_if.sv
// Bundle of the execute controller's request, ALU-side and writeback signals.
// The controller uses the slave view; the issuing side / ALU / register file
// collectively use the master view.
interface alu_exec_ctl_if;
  // Operation request from register-file read
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [7:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rd2;
  logic        in_setf;

  // Combinational ALU operands and results
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_ql;
  logic [31:0] alu_qh;
  logic [3:0]  alu_fout;

  // Register-file write port
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_last;

  // Architectural status
  logic [3:0]  flags;
  logic        exc_illegal;

  modport master (
    output in_valid, in_a, in_b, in_op, in_rd, in_rd2, in_setf,
    output alu_ql, alu_qh, alu_fout,
    output wb_ready,
    input  in_ready, alu_a, alu_b, alu_op,
    input  wb_valid, wb_addr, wb_data, wb_last, flags, exc_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_rd, in_rd2, in_setf,
    input  alu_ql, alu_qh, alu_fout,
    input  wb_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output wb_valid, wb_addr, wb_data, wb_last, flags, exc_illegal
  );
endinterface

// File: rtl/alu_exec_ctl.sv
// Execute-stage controller in front of the combinational alu32_2x2.
// Accepts one op at a time, holds the ALU operands for SETTLE_CYCLES cycles,
// captures the results and streams one or two write beats to the register file.
module alu_exec_ctl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctl_if.slave  bus
);

  // Counter starts one below the budget: the capture edge itself is the last settle cycle.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] OP_MAX   = 8'd17;
  localparam logic [7:0] OP_PAIR  = 8'd0;
  localparam logic [7:0] OP_MUL   = 8'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WB_LO  = 2'd2,
    WB_HI  = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [4:0]  rd_q;
  logic [4:0]  rd2_q;
  logic        setf_q;
  logic        dual_q;
  logic [31:0] res_hi_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [7:0]  alu_op_q;
  logic [3:0]  flags_q;
  logic        exc_q;
  logic        wb_valid_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        wb_last_q;

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.flags       = flags_q;
  assign bus.exc_illegal = exc_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_last     = wb_last_q;

  // Control FSM with registered ALU operands, flags and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 5'd0;
      rd2_q      <= 5'd0;
      setf_q     <= 1'b0;
      dual_q     <= 1'b0;
      res_hi_q   <= 32'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_op_q   <= 8'd0;
      flags_q    <= 4'd0;
      exc_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      wb_last_q  <= 1'b0;
    end else begin
      // The exception flag is a pulse; it only survives a cycle if re-armed below.
      exc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_op <= OP_MAX) begin
              alu_a_q  <= bus.in_a;
              alu_b_q  <= bus.in_b;
              alu_op_q <= bus.in_op;
              rd_q     <= bus.in_rd;
              rd2_q    <= bus.in_rd2;
              setf_q   <= bus.in_setf;
              dual_q   <= (bus.in_op == OP_PAIR) || (bus.in_op == OP_MUL);
              cnt_q    <= CNT_INIT;
              state_q  <= SETTLE;
            end else begin
              // Illegal ops are consumed in place; nothing else is disturbed.
              exc_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            res_hi_q   <= bus.alu_qh;
            if (setf_q) begin
              flags_q <= bus.alu_fout;
            end
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_q;
            wb_data_q  <= bus.alu_ql;
            wb_last_q  <= !dual_q;
            state_q    <= WB_LO;
          end
        end
        WB_LO: begin
          if (bus.wb_ready) begin
            if (dual_q) begin
              wb_addr_q <= rd2_q;
              wb_data_q <= res_hi_q;
              wb_last_q <= 1'b1;
              state_q   <= WB_HI;
            end else begin
              wb_valid_q <= 1'b0;
              wb_addr_q  <= 5'd0;
              wb_data_q  <= 32'd0;
              wb_last_q  <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        WB_HI: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_last_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
